// File: rtl/mips_pkg.sv
// mips_pkg: state encoding, opcode/func values and control-field encodings shared by the multi-cycle controller.
package mips_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A, F_JR = 6'h08;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;
  localparam logic [1:0] B_REG = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10, B_SHL2 = 2'b11;
endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: ALU operation per controller state, plus R-type func legality.
module mips_alu_dec
  import mips_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opc,
  input  logic [5:0]  i_func,
  output logic [2:0]  o_alu_op,
  output logic        o_func_ok
);
  logic [2:0] w_rop;
  always_comb begin
    w_rop = ALU_ADD;
    o_func_ok = 1'b1;
    case (i_func)
      F_ADD, F_JR: w_rop = ALU_ADD;
      F_SUB:       w_rop = ALU_SUB;
      F_AND:       w_rop = ALU_AND;
      F_OR:        w_rop = ALU_OR;
      F_SLT:       w_rop = ALU_SLT;
      default:     o_func_ok = 1'b0;
    endcase
  end
  assign o_alu_op = (i_state == S_FETCH || i_state == S_DECODE || i_state == S_MEMADR) ? ALU_ADD :
                    (i_state == S_EXEC)   ? w_rop :
                    (i_state == S_IEXEC)  ? ((i_opc == OP_SLTI) ? ALU_SLT : ALU_ADD) :
                    (i_state == S_BRANCH) ? ALU_SUB : ALU_AND;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with memory req/ready timeout and sticky traps.
// Optional macro MIPS_BNE_EN adds bne (opcode 0x05) as a branch taken on ~zero.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TMO_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       bus_err,
  output logic       illegal
);
  state_t           r_state;
  state_t           w_dec;
  logic [TMO_W-1:0] r_cnt;
  logic             r_bus_err, r_illegal;
  logic             w_func_ok, w_mem_st, w_tmo, w_take;

  mips_alu_dec u_alu_dec (
    .i_state  (r_state),
    .i_opc    (opc),
    .i_func   (func),
    .o_alu_op (alu_op),
    .o_func_ok(w_func_ok)
  );

  assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == TMO_W'(TIMEOUT)) && !mem_ready;
  assign bus_err  = r_bus_err;
  assign illegal  = r_illegal;
`ifdef MIPS_BNE_EN
  assign w_take = (opc == OP_BNE) ? ~zero : zero;
`else
  assign w_take = zero;
`endif

  always_comb begin
    w_dec = S_TRAP;
    case (opc)
      OP_LW, OP_SW:     w_dec = S_MEMADR;
      OP_RTYPE:         w_dec = (func == F_JR) ? S_JR : w_func_ok ? S_EXEC : S_TRAP;
      OP_BEQ:           w_dec = S_BRANCH;
`ifdef MIPS_BNE_EN
      OP_BNE:           w_dec = S_BRANCH;
`endif
      OP_J:             w_dec = S_JUMP;
      OP_JAL:           w_dec = S_JAL;
      OP_ADDI, OP_SLTI: w_dec = S_IEXEC;
      default:          w_dec = S_TRAP;
    endcase
  end

  // The wait counter is zero on entry to any memory state because every other state clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_cnt <= (w_mem_st && !mem_ready) ? r_cnt + 1'b1 : '0;
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) r_state <= (r_state == S_FETCH) ? S_DECODE : (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
          else if (w_tmo) begin
            r_state   <= S_TRAP;
            r_bus_err <= 1'b1;
          end
        end
        S_DECODE: begin
          r_state <= w_dec;
          if (w_dec == S_TRAP) r_illegal <= 1'b1;
        end
        S_MEMADR: r_state <= (opc == OP_SW) ? S_MEMWR : S_MEMRD;
        S_EXEC:   r_state <= S_RWB;
        S_IEXEC:  r_state <= S_IWB;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
    pc_src = PC_ALU; reg_write = 1'b0; reg_dst = RD_RT; mem_to_reg = WB_ALU;
    alu_src_a = 1'b0; alu_src_b = B_REG; retire = 1'b0;
    case (r_state)
      S_FETCH:  begin mem_req = 1'b1; alu_src_b = B_FOUR; ir_write = mem_ready; pc_write = mem_ready; pc_src = PC_ALU; end
      S_DECODE: alu_src_b = B_SHL2;
      S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = B_IMM; end
      S_MEMRD:  begin mem_req = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin reg_write = 1'b1; reg_dst = RD_RT; mem_to_reg = WB_MDR; retire = 1'b1; end
      S_MEMWR:  begin mem_req = 1'b1; mem_we = 1'b1; iord = 1'b1; retire = mem_ready; end
      S_EXEC:   begin alu_src_a = 1'b1; alu_src_b = B_REG; end
      S_RWB:    begin reg_write = 1'b1; reg_dst = RD_RD; mem_to_reg = WB_ALU; retire = 1'b1; end
      S_IEXEC:  begin alu_src_a = 1'b1; alu_src_b = B_IMM; end
      S_IWB:    begin reg_write = 1'b1; reg_dst = RD_RT; mem_to_reg = WB_ALU; retire = 1'b1; end
      S_BRANCH: begin alu_src_a = 1'b1; pc_src = PC_ALUOUT; pc_write = w_take; retire = 1'b1; end
      S_JUMP:   begin pc_src = PC_JUMP; pc_write = 1'b1; retire = 1'b1; end
      S_JAL:    begin pc_src = PC_JUMP; pc_write = 1'b1; reg_write = 1'b1; reg_dst = RD_RA; mem_to_reg = WB_PC; retire = 1'b1; end
      S_JR:     begin pc_src = PC_RS; pc_write = 1'b1; retire = 1'b1; end
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven instruction sequencing checks plus hand-written wait, timeout and reset sequences.
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       retire;
  } ctrl_t;
  typedef struct {
    string      name;
    logic [5:0] opc, func;
    logic       zero;
    int         ncyc;
    ctrl_t      ctrl;
    logic [2:0] prev_op;
    logic       ill;
  } vec_t;

  logic clk = 0, rst = 0, zero = 0, mem_ready = 0;
  logic [5:0] opc = 0, func = 0;
  logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src_a, retire, bus_err, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;
  ctrl_t ctrl;
  int tests = 0, fails = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .bus_err(bus_err), .illegal(illegal)
  );

  assign ctrl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, retire};

  function automatic ctrl_t ctl(input logic mr, we, io, irw, pcw, input logic [1:0] pcs, input logic rw,
                                input logic [1:0] rd, m2r, input logic a, input logic [1:0] b,
                                input logic [2:0] op, input logic ret);
    return {mr, we, io, irw, pcw, pcs, rw, rd, m2r, a, b, op, ret};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Holds reset across a negedge, then releases it so the next posedge leaves IDLE.
  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    logic [2:0] prev = 3'b000;
    ctrl_t last = '0;
    logic strobe = 0;
    opc = v.opc; func = v.func; zero = v.zero; mem_ready = 1;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (v.ill && c >= 3 && (ctrl != '0)) strobe = 1;
      if (!v.ill && retire && n == 0) begin n = c; last = ctrl; end
      if (n == 0) prev = alu_op;
    end
    if (v.ill) begin
      chk({v.name, " illegal"}, 32'(illegal), 32'd1);
      chk({v.name, " strobes in trap"}, 32'(strobe), 32'd0);
    end else begin
      chk({v.name, " cycles"}, n, v.ncyc);
      chk({v.name, " retire ctrl"}, 32'(last), 32'(v.ctrl));
      chk({v.name, " prev alu_op"}, 32'(prev), 32'(v.prev_op));
    end
  endtask

  initial begin
    int rcnt;
    vq.push_back('{"lw",   6'h23, 6'h00, 1'b0, 5, ctl(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,2'b00,3'b000,1), 3'b000, 1'b0});
    vq.push_back('{"sw",   6'h2B, 6'h00, 1'b0, 4, ctl(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,1), 3'b010, 1'b0});
    vq.push_back('{"add",  6'h00, 6'h20, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1), 3'b010, 1'b0});
    vq.push_back('{"sub",  6'h00, 6'h22, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1), 3'b110, 1'b0});
    vq.push_back('{"and",  6'h00, 6'h24, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1), 3'b000, 1'b0});
    vq.push_back('{"or",   6'h00, 6'h25, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1), 3'b001, 1'b0});
    vq.push_back('{"slt",  6'h00, 6'h2A, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1), 3'b111, 1'b0});
    vq.push_back('{"addi", 6'h08, 6'h00, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,3'b000,1), 3'b010, 1'b0});
    vq.push_back('{"slti", 6'h0A, 6'h00, 1'b0, 4, ctl(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,3'b000,1), 3'b111, 1'b0});
    vq.push_back('{"beq_t",6'h04, 6'h00, 1'b1, 3, ctl(0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,3'b110,1), 3'b010, 1'b0});
    vq.push_back('{"beq_n",6'h04, 6'h00, 1'b0, 3, ctl(0,0,0,0,0,2'b01,0,2'b00,2'b00,1,2'b00,3'b110,1), 3'b010, 1'b0});
    vq.push_back('{"j",    6'h02, 6'h00, 1'b0, 3, ctl(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,2'b00,3'b000,1), 3'b010, 1'b0});
    vq.push_back('{"jal",  6'h03, 6'h00, 1'b0, 3, ctl(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,2'b00,3'b000,1), 3'b010, 1'b0});
    vq.push_back('{"jr",   6'h00, 6'h08, 1'b0, 3, ctl(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,2'b00,3'b000,1), 3'b010, 1'b0});
`ifdef MIPS_BNE_EN
    vq.push_back('{"bne_z",6'h05, 6'h00, 1'b1, 3, ctl(0,0,0,0,0,2'b01,0,2'b00,2'b00,1,2'b00,3'b110,1), 3'b010, 1'b0});
    vq.push_back('{"bne_n",6'h05, 6'h00, 1'b0, 3, ctl(0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,3'b110,1), 3'b010, 1'b0});
`else
    vq.push_back('{"bne",  6'h05, 6'h00, 1'b0, 0, ctrl_t'('0), 3'b000, 1'b1});
`endif
    vq.push_back('{"opc3f",6'h3F, 6'h00, 1'b0, 0, ctrl_t'('0), 3'b000, 1'b1});
    vq.push_back('{"fn03", 6'h00, 6'h03, 1'b0, 0, ctrl_t'('0), 3'b000, 1'b1});

    // Reset state and first FETCH
    rst = 0; mem_ready = 0; opc = 6'h23;
    @(negedge clk);
    chk("in reset ctrl", 32'(ctrl), 32'd0);
    chk("in reset flags", {30'd0, bus_err, illegal}, 32'd0);
    rst = 1;
    #1 chk("idle ctrl", 32'(ctrl), 32'd0);
    cyc();
    chk("fetch mem_req", 32'(mem_req), 32'd1);
    chk("fetch iord", 32'(iord), 32'd0);
    chk("fetch alu_src_b", 32'(alu_src_b), 32'd1);

    foreach (vq[i]) run_vec(vq[i]);

    // lw with two wait cycles on each memory access
    opc = 6'h23; func = 0; mem_ready = 0;
    do_reset();
    rcnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1 mem_ready = (c == 3 || c == 8);
      @(negedge clk);
      if (retire) rcnt++;
      if (c == 7) chk("lw memrd iord", {30'd0, mem_req, iord}, 32'd3);
      if (c == 9) chk("lw memwb", {29'd0, retire, reg_write, mem_to_reg == 2'b01}, 32'd7);
    end
    chk("lw retire count", rcnt, 1);

    // Timeout in FETCH
    mem_ready = 0;
    do_reset();
    for (int c = 1; c <= 16; c++) cyc();
    chk("tmo last fetch", {30'd0, mem_req, bus_err}, 32'd2);
    cyc();
    chk("tmo trap", {30'd0, mem_req, bus_err}, 32'd1);
    for (int c = 0; c < 5; c++) cyc();
    chk("tmo sticky", 32'(bus_err), 32'd1);
    rst = 0;
    #1 chk("tmo cleared by reset", 32'(bus_err), 32'd0);

    // Ready arriving exactly in the limit cycle wins
    mem_ready = 0;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1 mem_ready = (c == 16);
      @(negedge clk);
    end
    chk("limit ir_write", 32'(ir_write), 32'd1);
    @(posedge clk);
    #1 mem_ready = 0;
    @(negedge clk);
    chk("limit decode", {29'd0, bus_err, alu_src_b}, 32'd3);

    // Reset asserted while a store waits for memory
    opc = 6'h2B; mem_ready = 1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1 mem_ready = (c < 4);
      @(negedge clk);
    end
    chk("memwr waiting", {30'd0, mem_req, mem_we}, 32'd3);
    #2 rst = 0;
    #1 chk("memwr reset drop", 32'(ctrl), 32'd0);
    @(negedge clk);
    rst = 1;
    #1 chk("restart idle", 32'(ctrl), 32'd0);
    cyc();
    chk("restart fetch", {30'd0, mem_req, iord}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
